// File: rtl/vga_pattern_seq.sv
// rtl/vga_pattern_seq.sv - frame-synchronous pattern sequencer for the VGA test-pattern generator.
// Optional force-black frame after each pattern change: define VGA_SEQ_BLANK_EN.
module vga_pattern_seq #(
  parameter int DWELL_FRAMES = 120,
  parameter int NUM_PATTERNS = 4,
  parameter int DEB_CYCLES   = 16
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic [9:0] iVGA_X,
  input  logic [9:0] iVGA_Y,
  input  logic       iStep_n,
  input  logic       iAuto,
  output logic [1:0] oPattern,
  output logic       oColor_SW,
  output logic       oMono,
  output logic       oBlank,
  output logic       oFrame_Tick
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_AUTO = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  logic [9:0]       prev_y;
  logic             frame_start;
  logic             sync1;
  logic             sync2;
  logic [DEB_W-1:0] deb_cnt;
  logic             btn_level;
  logic             deb_hit;
  logic             btn_fall;
  logic             step_req;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [11:0]      dwell_cnt;
  logic             counting;
  logic             step_adv;
  logic             dwell_adv;
  logic             advance;
  logic [1:0]       next_pat;

  assign frame_start = (iVGA_Y == 10'd0) && (prev_y != 10'd0);

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      prev_y <= 10'd0;
    end else begin
      prev_y <= iVGA_Y;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= iStep_n;
      sync2 <= sync1;
    end
  end

  // Any sample equal to the accepted level restarts the run of differing samples.
  assign deb_hit  = (sync2 != btn_level) && (deb_cnt == DEB_W'(DEB_CYCLES - 1));
  assign btn_fall = deb_hit && btn_level;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      deb_cnt   <= '0;
      btn_level <= 1'b1;
    end else if (sync2 == btn_level) begin
      deb_cnt <= '0;
    end else if (deb_hit) begin
      deb_cnt   <= '0;
      btn_level <= sync2;
    end else begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  assign counting  = iAuto && ((state == S_AUTO) || (state == S_PEND));
  assign step_adv  = frame_start && (state == S_PEND);
  assign dwell_adv = frame_start && counting && (dwell_cnt == 12'(DWELL_FRAMES - 1));
  assign advance   = step_adv || dwell_adv;
  assign next_pat  = (oPattern == 2'(NUM_PATTERNS - 1)) ? 2'd0 : oPattern + 2'd1;

  always_comb begin
    state_nxt = state;
    case (state)
      S_HOLD: begin
        if (step_req)   state_nxt = S_PEND;
        else if (iAuto) state_nxt = S_AUTO;
      end
      S_AUTO: begin
        if (step_req)    state_nxt = S_PEND;
        else if (!iAuto) state_nxt = S_HOLD;
      end
      S_PEND: begin
        if (frame_start) state_nxt = iAuto ? S_AUTO : S_HOLD;
      end
      default: state_nxt = S_HOLD;
    endcase
  end

  // A new button edge wins over the clear, so it is served at the following frame start.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state     <= S_HOLD;
      step_req  <= 1'b0;
      dwell_cnt <= 12'd0;
    end else begin
      state <= state_nxt;
      if (btn_fall)      step_req <= 1'b1;
      else if (step_adv) step_req <= 1'b0;
      if (!iAuto || advance)         dwell_cnt <= 12'd0;
      else if (frame_start && counting) dwell_cnt <= dwell_cnt + 12'd1;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oPattern    <= 2'd0;
      oColor_SW   <= 1'b1;
      oMono       <= 1'b0;
      oFrame_Tick <= 1'b0;
    end else begin
      oFrame_Tick <= frame_start;
      if (advance) begin
        oPattern  <= next_pat;
        oColor_SW <= ~next_pat[0];
        oMono     <= next_pat[1];
      end
    end
  end

`ifdef VGA_SEQ_BLANK_EN
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oBlank <= 1'b0;
    end else if (advance) begin
      oBlank <= 1'b1;
    end else if (frame_start) begin
      oBlank <= 1'b0;
    end
  end
`else
  assign oBlank = 1'b0;
`endif

`ifndef SYNTHESIS
  a_x_at_frame_start: assert property (
    @(posedge iVGA_CLK) disable iff (!iRST_n) frame_start |-> (iVGA_X == 10'd0)
  );
`endif

endmodule
